// File: rtl/df_mon_pkg.sv
// Shared definitions for the dataflow activity monitor.
//   proc_state_e        : per-process tracking state (IDLE, ACTIVE, DONE_WAIT)
//   FIFO/PROC/MOD_WORDS : number of readout words per tracked object
//   proc_base/mod_base/cycle_addr : readout word bases derived from NF/NP/NM
package df_mon_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVE    = 2'd1,
        DONE_WAIT = 2'd2
    } proc_state_e;

    localparam int FIFO_WORDS = 4;
    localparam int PROC_WORDS = 4;
    localparam int MOD_WORDS  = 2;

    function automatic int proc_base(input int nf);
        return nf * FIFO_WORDS;
    endfunction

    function automatic int mod_base(input int nf, input int np);
        return nf * FIFO_WORDS + np * PROC_WORDS;
    endfunction

    function automatic int cycle_addr(input int nf, input int np, input int nm);
        return mod_base(nf, np) + nm * MOD_WORDS;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset, clears q
//   inc   : count one event this cycle
//   hold  : freeze the counter (overrides inc)
//   q     : current count, sticks at all-ones
module sat_counter #(
    parameter int CW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inc,
    input  logic          hold,
    output logic [CW-1:0] q
);

    logic [CW-1:0] q_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_reg <= '0;
        end else if (inc && !hold && (q_reg != '1)) begin
            q_reg <= q_reg + CW'(1);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/df_activity_monitor.sv
// Activity monitor for an HLS dataflow region. Taps the FIFO, process and
// sub-module handshakes and keeps occupancy, blocking, stall and busy
// statistics, readable through a registered word-addressed port.
//   clock, reset            : clock and asynchronous active-low reset
//   finish                  : end of run; statistics freeze from the next cycle
//   fifo_*                  : per-channel push/pop strobes and blocked flags
//   proc_*                  : per-process handshakes and stall flags
//   mod_*                   : per-module handshakes
//   rd_addr / rd_data       : word select and registered read data (1-cycle latency)
//   frozen                  : statistics frozen
//   proc_state              : 2-bit state code per process
//   mod_busy                : busy flag per module
module df_activity_monitor
    import df_mon_pkg::*;
#(
    parameter int NF = 6,
    parameter int NP = 3,
    parameter int NM = 3,
    parameter int CW = 32,
    parameter int AW = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            finish,
    input  logic [NF-1:0]   fifo_rd_en,
    input  logic [NF-1:0]   fifo_wr_en,
    input  logic [NF-1:0]   fifo_rd_block,
    input  logic [NF-1:0]   fifo_wr_block,
    input  logic [NP-1:0]   proc_ap_start,
    input  logic [NP-1:0]   proc_ap_ready,
    input  logic [NP-1:0]   proc_ap_done,
    input  logic [NP-1:0]   proc_ap_continue,
    input  logic [NP-1:0]   proc_real_start,
    input  logic [NP-1:0]   proc_pin_stall,
    input  logic [NP-1:0]   proc_pout_stall,
    input  logic [NM-1:0]   mod_ap_start,
    input  logic [NM-1:0]   mod_ap_ready,
    input  logic [NM-1:0]   mod_ap_done,
    input  logic [NM-1:0]   mod_ap_continue,
    input  logic [AW-1:0]   rd_addr,
    output logic [CW-1:0]   rd_data,
    output logic            frozen,
    output logic [2*NP-1:0] proc_state,
    output logic [NM-1:0]   mod_busy
);

    localparam int PROC_BASE = proc_base(NF);
    localparam int MOD_BASE  = mod_base(NF, NP);
    localparam int CYC_ADDR  = cycle_addr(NF, NP, NM);
    localparam int NW        = CYC_ADDR + 1;

    logic          frozen_reg;
    logic [CW-1:0] words [NW];
    logic [CW-1:0] rd_data_reg, rd_data_next;

    // Process tracking keys off real_start rather than ap_start, and ap_ready
    // carries no information the statistics need; kept on the port list so
    // the monitor taps the full handshake bundle.
    logic unused_handshakes;
    assign unused_handshakes = ^{proc_ap_start, proc_ap_ready, mod_ap_ready};

    // Freeze takes effect one cycle after finish, so events in the finish
    // cycle itself are still counted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frozen_reg <= 1'b0;
        end else if (finish) begin
            frozen_reg <= 1'b1;
        end
    end

    sat_counter #(.CW(CW)) u_cycle_count (
        .clock(clock), .reset(reset), .inc(1'b1), .hold(frozen_reg), .q(words[CYC_ADDR])
    );

    genvar gi;

    // FIFO trackers
    for (gi = 0; gi < NF; gi++) begin : g_fifo
        logic [CW-1:0] depth_reg, depth_next, max_reg;

        always_comb begin
            depth_next = depth_reg;
            if (fifo_wr_en[gi] && !fifo_rd_en[gi]) begin
                if (depth_reg != '1) depth_next = depth_reg + CW'(1);
            end else if (fifo_rd_en[gi] && !fifo_wr_en[gi]) begin
                // A pop seen at zero depth is clamped rather than wrapping.
                if (depth_reg != '0) depth_next = depth_reg - CW'(1);
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                depth_reg <= '0;
                max_reg   <= '0;
            end else if (!frozen_reg) begin
                depth_reg <= depth_next;
                if (depth_next > max_reg) max_reg <= depth_next;
            end
        end

        sat_counter #(.CW(CW)) u_rd_block (
            .clock(clock), .reset(reset), .inc(fifo_rd_block[gi]), .hold(frozen_reg),
            .q(words[FIFO_WORDS*gi + 2])
        );
        sat_counter #(.CW(CW)) u_wr_block (
            .clock(clock), .reset(reset), .inc(fifo_wr_block[gi]), .hold(frozen_reg),
            .q(words[FIFO_WORDS*gi + 3])
        );

        assign words[FIFO_WORDS*gi + 0] = depth_reg;
        assign words[FIFO_WORDS*gi + 1] = max_reg;
    end

    // Dataflow process trackers
    for (gi = 0; gi < NP; gi++) begin : g_proc
        proc_state_e state_reg, state_next;
        logic        iter_inc;
        logic        is_active;

        always_comb begin
            state_next = state_reg;
            iter_inc   = 1'b0;
            case (state_reg)
                IDLE: begin
                    if (proc_real_start[gi]) state_next = ACTIVE;
                end
                ACTIVE: begin
                    if (proc_ap_done[gi]) begin
                        if (proc_ap_continue[gi]) begin
                            iter_inc   = 1'b1;
                            state_next = proc_real_start[gi] ? ACTIVE : IDLE;
                        end else begin
                            state_next = DONE_WAIT;
                        end
                    end
                end
                DONE_WAIT: begin
                    // Iteration completes only once the consumer lets it go.
                    if (proc_ap_continue[gi]) begin
                        iter_inc   = 1'b1;
                        state_next = proc_real_start[gi] ? ACTIVE : IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state_reg <= IDLE;
            end else if (!frozen_reg) begin
                state_reg <= state_next;
            end
        end

        assign is_active = (state_reg == ACTIVE);

        sat_counter #(.CW(CW)) u_iter (
            .clock(clock), .reset(reset), .inc(iter_inc), .hold(frozen_reg),
            .q(words[PROC_BASE + PROC_WORDS*gi + 0])
        );
        sat_counter #(.CW(CW)) u_active (
            .clock(clock), .reset(reset), .inc(is_active), .hold(frozen_reg),
            .q(words[PROC_BASE + PROC_WORDS*gi + 1])
        );
        sat_counter #(.CW(CW)) u_in_stall (
            .clock(clock), .reset(reset), .inc(is_active && proc_pin_stall[gi]), .hold(frozen_reg),
            .q(words[PROC_BASE + PROC_WORDS*gi + 2])
        );
        sat_counter #(.CW(CW)) u_out_stall (
            .clock(clock), .reset(reset), .inc(is_active && proc_pout_stall[gi]), .hold(frozen_reg),
            .q(words[PROC_BASE + PROC_WORDS*gi + 3])
        );

        assign proc_state[2*gi +: 2] = state_reg;
    end

    // Non-dataflow module trackers
    for (gi = 0; gi < NM; gi++) begin : g_mod
        logic busy_reg, busy_next;
        logic call_done;

        assign call_done = mod_ap_done[gi] && mod_ap_continue[gi];

        // While busy, a back-to-back start in the completing cycle keeps the
        // module busy for the next call.
        always_comb begin
            busy_next = busy_reg ? (!call_done || mod_ap_start[gi]) : mod_ap_start[gi];
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                busy_reg <= 1'b0;
            end else if (!frozen_reg) begin
                busy_reg <= busy_next;
            end
        end

        sat_counter #(.CW(CW)) u_calls (
            .clock(clock), .reset(reset), .inc(call_done), .hold(frozen_reg),
            .q(words[MOD_BASE + MOD_WORDS*gi + 0])
        );
        sat_counter #(.CW(CW)) u_busy_cycles (
            .clock(clock), .reset(reset), .inc(busy_reg), .hold(frozen_reg),
            .q(words[MOD_BASE + MOD_WORDS*gi + 1])
        );

        assign mod_busy[gi] = busy_reg;
    end

    // Readout mux; addresses past the cycle counter fall through to zero.
    always_comb begin
        rd_data_next = '0;
        for (int i = 0; i < NW; i++) begin
            if (rd_addr == AW'(i)) rd_data_next = words[i];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= rd_data_next;
        end
    end

    assign rd_data = rd_data_reg;
    assign frozen  = frozen_reg;

endmodule

// File: tb/tb_df_activity_monitor.sv
// Self-checking bench for df_activity_monitor: directed scenarios followed by
// random traffic, every cycle compared against a behavioural model.
module tb_df_activity_monitor;

    localparam int NF = 6;
    localparam int NP = 3;
    localparam int NM = 3;
    localparam int CW = 32;
    localparam int AW = 6;
    localparam int CYC_WORD = 4*NF + 4*NP + 2*NM;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            finish;
    logic [NF-1:0]   fifo_rd_en, fifo_wr_en, fifo_rd_block, fifo_wr_block;
    logic [NP-1:0]   proc_ap_start, proc_ap_ready, proc_ap_done, proc_ap_continue;
    logic [NP-1:0]   proc_real_start, proc_pin_stall, proc_pout_stall;
    logic [NM-1:0]   mod_ap_start, mod_ap_ready, mod_ap_done, mod_ap_continue;
    logic [AW-1:0]   rd_addr;
    logic [CW-1:0]   rd_data;
    logic            frozen;
    logic [2*NP-1:0] proc_state;
    logic [NM-1:0]   mod_busy;

    always #5 clock = ~clock;

    df_activity_monitor #(.NF(NF), .NP(NP), .NM(NM), .CW(CW), .AW(AW)) dut (
        .clock(clock), .reset(reset), .finish(finish),
        .fifo_rd_en(fifo_rd_en), .fifo_wr_en(fifo_wr_en),
        .fifo_rd_block(fifo_rd_block), .fifo_wr_block(fifo_wr_block),
        .proc_ap_start(proc_ap_start), .proc_ap_ready(proc_ap_ready),
        .proc_ap_done(proc_ap_done), .proc_ap_continue(proc_ap_continue),
        .proc_real_start(proc_real_start), .proc_pin_stall(proc_pin_stall),
        .proc_pout_stall(proc_pout_stall),
        .mod_ap_start(mod_ap_start), .mod_ap_ready(mod_ap_ready),
        .mod_ap_done(mod_ap_done), .mod_ap_continue(mod_ap_continue),
        .rd_addr(rd_addr), .rd_data(rd_data), .frozen(frozen),
        .proc_state(proc_state), .mod_busy(mod_busy)
    );

    // Behavioural model: plain integer statistics per object.
    int unsigned m_depth [NF], m_max [NF], m_rdb [NF], m_wrb [NF];
    int          m_st    [NP];
    int unsigned m_iter  [NP], m_act [NP], m_ins [NP], m_outs [NP];
    bit          m_busy  [NM];
    int unsigned m_calls [NM], m_busyc [NM];
    int unsigned m_cyc;
    bit          m_frozen;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NF; i++) begin
            m_depth[i] = 0; m_max[i] = 0; m_rdb[i] = 0; m_wrb[i] = 0;
        end
        for (int j = 0; j < NP; j++) begin
            m_st[j] = 0; m_iter[j] = 0; m_act[j] = 0; m_ins[j] = 0; m_outs[j] = 0;
        end
        for (int k = 0; k < NM; k++) begin
            m_busy[k] = 0; m_calls[k] = 0; m_busyc[k] = 0;
        end
        m_cyc = 0;
        m_frozen = 0;
    endtask

    // One clock of the model, from the inputs currently driven.
    task automatic model_step();
        if (m_frozen) return;
        m_cyc++;
        for (int i = 0; i < NF; i++) begin
            if (fifo_wr_en[i] && !fifo_rd_en[i]) m_depth[i]++;
            else if (fifo_rd_en[i] && !fifo_wr_en[i] && m_depth[i] > 0) m_depth[i]--;
            if (m_depth[i] > m_max[i]) m_max[i] = m_depth[i];
            m_rdb[i] += int'(fifo_rd_block[i]);
            m_wrb[i] += int'(fifo_wr_block[i]);
        end
        for (int j = 0; j < NP; j++) begin
            if (m_st[j] == 1) begin
                m_act[j]++;
                m_ins[j]  += int'(proc_pin_stall[j]);
                m_outs[j] += int'(proc_pout_stall[j]);
            end
            if (m_st[j] == 0 && proc_real_start[j]) begin
                m_st[j] = 1;
            end else if ((m_st[j] == 1 && proc_ap_done[j]) || m_st[j] == 2) begin
                if (proc_ap_continue[j]) begin
                    m_iter[j]++;
                    m_st[j] = proc_real_start[j] ? 1 : 0;
                end else begin
                    m_st[j] = 2;
                end
            end
        end
        for (int k = 0; k < NM; k++) begin
            bit cd;
            cd = mod_ap_done[k] && mod_ap_continue[k];
            if (cd) m_calls[k]++;
            if (m_busy[k]) m_busyc[k]++;
            if (!m_busy[k]) m_busy[k] = mod_ap_start[k];
            else if (cd && !mod_ap_start[k]) m_busy[k] = 0;
        end
        if (finish) m_frozen = 1;
    endtask

    function automatic logic [CW-1:0] model_word(input int a);
        int r;
        if (a < 4*NF) begin
            r = a % 4;
            case (r)
                0: return m_depth[a/4];
                1: return m_max[a/4];
                2: return m_rdb[a/4];
                default: return m_wrb[a/4];
            endcase
        end else if (a < 4*NF + 4*NP) begin
            r = (a - 4*NF) % 4;
            case (r)
                0: return m_iter[(a-4*NF)/4];
                1: return m_act[(a-4*NF)/4];
                2: return m_ins[(a-4*NF)/4];
                default: return m_outs[(a-4*NF)/4];
            endcase
        end else if (a < CYC_WORD) begin
            if ((a - 4*NF - 4*NP) % 2 == 0) return m_calls[(a-4*NF-4*NP)/2];
            return m_busyc[(a-4*NF-4*NP)/2];
        end else if (a == CYC_WORD) begin
            return m_cyc;
        end
        return '0;
    endfunction

    function automatic logic [2*NP-1:0] model_pstate();
        logic [2*NP-1:0] v;
        v = '0;
        for (int j = 0; j < NP; j++) v[2*j +: 2] = 2'(m_st[j]);
        return v;
    endfunction

    function automatic logic [NM-1:0] model_busy();
        logic [NM-1:0] v;
        for (int k = 0; k < NM; k++) v[k] = m_busy[k];
        return v;
    endfunction

    task automatic clear_inputs();
        finish = 0;
        fifo_rd_en = '0; fifo_wr_en = '0; fifo_rd_block = '0; fifo_wr_block = '0;
        proc_ap_start = '0; proc_ap_ready = '0; proc_ap_done = '0; proc_ap_continue = '0;
        proc_real_start = '0; proc_pin_stall = '0; proc_pout_stall = '0;
        mod_ap_start = '0; mod_ap_ready = '0; mod_ap_done = '0; mod_ap_continue = '1;
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic cycle();
        logic [CW-1:0] e;
        e = model_word(int'(rd_addr));
        @(posedge clock);
        model_step();
        @(negedge clock);
        check("rd_data", rd_data, e);
        check("frozen", frozen, m_frozen);
        check("proc_state", proc_state, model_pstate());
        check("mod_busy", mod_busy, model_busy());
    endtask

    task automatic read_check(input int a, input logic [CW-1:0] exp, input string tag);
        clear_inputs();
        rd_addr = AW'(a);
        cycle();
        check(tag, rd_data, exp);
    endtask

    initial begin
        clear_inputs();
        rd_addr = '0;
        model_reset();
        #1 reset = 0;
        #2;
        check("reset_rd_data", rd_data, 0);
        check("reset_frozen", frozen, 0);
        check("reset_proc_state", proc_state, 0);
        check("reset_mod_busy", mod_busy, 0);
        @(negedge clock);
        reset = 1;

        // FIFO 0 depth profile
        repeat (5) begin clear_inputs(); fifo_wr_en[0] = 1; cycle(); end
        read_check(0, 5, "fifo0_depth_after_writes");
        repeat (2) begin clear_inputs(); fifo_wr_en[0] = 1; fifo_rd_en[0] = 1; cycle(); end
        read_check(0, 5, "fifo0_depth_after_rdwr");
        repeat (3) begin clear_inputs(); fifo_rd_en[0] = 1; cycle(); end
        read_check(0, 2, "fifo0_depth_after_3_reads");
        repeat (4) begin clear_inputs(); fifo_rd_en[0] = 1; cycle(); end
        read_check(0, 0, "fifo0_depth_floor");
        read_check(1, 5, "fifo0_max_depth");

        // Process 0 lifecycle
        clear_inputs(); proc_real_start[0] = 1; cycle();
        check("p0_state_active", proc_state[1:0], 2'd1);
        for (int i = 0; i < 9; i++) begin
            clear_inputs();
            proc_pin_stall[0] = (i < 8) && (i % 2 == 0);
            cycle();
        end
        clear_inputs(); proc_ap_done[0] = 1; cycle();
        check("p0_state_done_wait", proc_state[1:0], 2'd2);
        repeat (3) begin clear_inputs(); proc_ap_done[0] = 1; cycle(); end
        check("p0_state_still_waiting", proc_state[1:0], 2'd2);
        clear_inputs(); proc_ap_continue[0] = 1; cycle();
        check("p0_state_idle", proc_state[1:0], 2'd0);
        read_check(24, 1, "p0_iterations");
        read_check(25, 10, "p0_active_cycles");
        read_check(26, 4, "p0_in_stall");
        read_check(27, 0, "p0_out_stall");

        // Module 1 call
        clear_inputs(); mod_ap_start[1] = 1; cycle();
        check("m1_busy_set", mod_busy[1], 1);
        repeat (5) begin clear_inputs(); cycle(); end
        clear_inputs(); mod_ap_done[1] = 1; cycle();
        check("m1_busy_cleared", mod_busy[1], 0);
        read_check(38, 1, "m1_calls");
        read_check(39, 6, "m1_busy_cycles");

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            clear_inputs();
            fifo_wr_en       = NF'($urandom);
            fifo_rd_en       = NF'($urandom);
            fifo_rd_block    = NF'($urandom & $urandom);
            fifo_wr_block    = NF'($urandom & $urandom);
            proc_ap_start    = NP'($urandom);
            proc_ap_ready    = NP'($urandom);
            proc_real_start  = NP'($urandom & $urandom);
            proc_ap_done     = NP'($urandom & $urandom);
            proc_ap_continue = NP'($urandom);
            proc_pin_stall   = NP'($urandom);
            proc_pout_stall  = NP'($urandom);
            mod_ap_start     = NM'($urandom & $urandom);
            mod_ap_done      = NM'($urandom & $urandom);
            mod_ap_continue  = NM'($urandom);
            rd_addr          = AW'($urandom_range(0, 63));
            cycle();
        end

        // Asynchronous reset mid-run
        #2 reset = 0;
        model_reset();
        #1;
        check("async_rst_rd_data", rd_data, 0);
        check("async_rst_frozen", frozen, 0);
        check("async_rst_proc_state", proc_state, 0);
        check("async_rst_mod_busy", mod_busy, 0);
        @(negedge clock);
        clear_inputs();
        reset = 1;
        read_check(CYC_WORD, 0, "cycle_count_after_reset");
        read_check(1, 0, "fifo0_max_after_reset");

        // Blocking count then freeze
        repeat (7) begin clear_inputs(); fifo_rd_block[1] = 1; cycle(); end
        clear_inputs(); finish = 1; cycle();
        repeat (3) begin
            clear_inputs(); fifo_rd_block[1] = 1; fifo_wr_en[0] = 1; mod_ap_start[0] = 1; cycle();
        end
        read_check(6, 7, "fifo1_rd_block_frozen");
        check("frozen_set", frozen, 1);
        read_check(0, 0, "fifo0_depth_frozen");
        read_check(CYC_WORD, 10, "cycle_count_frozen");
        check("m0_busy_frozen", mod_busy[0], 0);
        read_check(63, 0, "unmapped_63");
        read_check(CYC_WORD + 1, 0, "unmapped_after_cycles");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
